control_pipeline: RTL and testbench
===================================

// Module: control_pipeline
// PURPOSE
// - Consumes the decoded control bundle and register fields from the ID-stage main decoder.
// - Carries them through the ID/EX, EX/MEM and MEM/WB control registers of the 5-stage MIPS pipeline.
// - Detects load-use hazards, inserts bubbles and squashes wrong-path instructions on a taken branch.
// - Keeps saturating stall and flush counters for debug.
// PARAMETERS
// - REG_ADDR_W  5   register-file address width (rs/rt/rd/dest)
// - CNT_W       16  width of stall/flush event counters
// PORTS
// clk                 in   1   rising-edge clock; only clock
// rst_n               in   1   synchronous, active-low reset
// id_valid_in         in   1   ID holds a real instruction (0 = bubble)
// RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in  in  1 each  decoder outputs, ID stage
// MemRead_in, MemWrite_in, Branch_in               in  1 each  decoder outputs, ID stage
// ALUOp_in            in   2   decoder ALUOp, ID stage
// rs_in, rt_in, rd_in in   REG_ADDR_W  ID instruction register fields
// branch_taken_in     in   1   datapath: mem_branch_out AND ALU zero, MEM stage
// ex_ALUSrc_out       out  1   ID/EX control, EX stage
// ex_ALUOp_out        out  2   ID/EX control, EX stage
// ex_dest_out         out  REG_ADDR_W  RegDst ? rd : rt, EX stage
// mem_MemRead_out, mem_MemWrite_out, mem_branch_out  out  1 each  EX/MEM control
// mem_RegWrite_out    out  1   EX/MEM RegWrite
// mem_dest_out        out  REG_ADDR_W  EX/MEM destination
// wb_RegWrite_out, wb_MemToReg_out  out  1 each  MEM/WB control
// wb_dest_out         out  REG_ADDR_W  MEM/WB destination
// pc_write_out        out  1   0 = hold PC this cycle
// ifid_write_out      out  1   0 = hold IF/ID this cycle
// flush_ifid_out      out  1   1 = load bubble into IF/ID
// stall_count_out     out  CNT_W  saturating count of stall cycles
// flush_count_out     out  CNT_W  saturating count of taken-branch flushes
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all stage control bits, dests and counters <= 0.
//   Combinational outputs then give pc_write_out=1, ifid_write_out=1, flush_ifid_out=0.
// - Latency: ID inputs sampled at edge N appear on ex_* at N+1, mem_* at N+2, wb_* at N+3.
//   A bubble has all control bits 0 and dest 0.
// - ex_dest is selected on entry to ID/EX: RegDst_in ? rd_in : rt_in.
// - Load-use hazard (comb.): hz = id_valid_in & ID/EX.MemRead & (ID/EX.rt != 0)
//   & (ID/EX.rt == rs_in | ID/EX.rt == rt_in).
//   - ID/EX.rt is the registered rt_in, stored separately from dest.
// - Stall (hz & ~branch_taken_in):
//   - pc_write_out=0, ifid_write_out=0.
//   - ID/EX <= bubble; EX/MEM and MEM/WB advance normally.
//   - stall_count++.
// - Taken branch (branch_taken_in=1, qualified by mem_branch_out):
//   - flush_ifid_out=1; ID/EX <= bubble; EX/MEM <= bubble.
//   - MEM/WB still captures the branch stage (no RegWrite).
//   - pc_write_out=1 and ifid_write_out=1 regardless of hz; flush wins over stall.
//   - flush_count++.
// - branch_taken_in while mem_branch_out=0 is ignored (no flush, no count).
// - Counters saturate at all-ones; no wrap-around.
// - id_valid_in=0: ID/EX <= bubble; no hazard is raised.
// - Reset mid-operation discards all in-flight control; no partial state survives.
// STRUCTURE
// - Shared package: localparams for control-bundle bit positions (9-bit bundle).
// - Shared package: ALUOp codes ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10.
// - Shared package: opcodes OP_RTYPE, OP_LW, OP_SW, OP_BEQ, for use by the decoder and this block.
// - One combinational sub-module: load_use_hazard_unit (inputs ex_memread, ex_rt, rs, rt, id_valid; output hz).
// - Stage registers and counters live in this module.
// TESTING
// 1 R-type (RegDst=1, rd=5, rt=3, ALUOp=10) -> ex_dest=5/ALUOp=10 at +1; mem_RegWrite=1, mem_dest=5 at +2; wb_dest=5 at +3.
// 2 lw rt=8, then add rs=8 -> next cycle: pc_write=0, ifid_write=0; ex_* bubble; stall_count=1; add enters EX the cycle after.
// 3 lw rt=0, then add rs=0 -> no stall, pc_write=1, stall_count=0.
// 4 beq in MEM with branch_taken=1 while hz=1 -> flush_ifid=1, pc_write=1; ID/EX and EX/MEM bubble; flush_count=1, stall_count unchanged.
// 5 Force stall_count=2^CNT_W-1 (CNT_W=4, 15 stalls) then one more stall -> stays 15.
// 6 Assert rst_n=0 for one edge mid-stream with lw in EX -> all outputs 0/defaults next cycle; counters 0.

Source files
------------

// File: rtl/control_pipeline_pkg.sv
// control_pipeline_pkg: shared control-bundle bit positions, ALUOp codes and opcodes
package control_pipeline_pkg;
  localparam int CTRL_W = 9;
  localparam int C_REGDST = 0;
  localparam int C_ALUSRC = 1;
  localparam int C_MEMTOREG = 2;
  localparam int C_REGWRITE = 3;
  localparam int C_MEMREAD = 4;
  localparam int C_MEMWRITE = 5;
  localparam int C_BRANCH = 6;
  localparam int C_ALUOP = 7;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} aluop_e;
  typedef enum logic [5:0] {OP_RTYPE = 6'h00, OP_BEQ = 6'h04, OP_LW = 6'h23, OP_SW = 6'h2b} opcode_e;
endpackage

// File: rtl/control_pipeline_hazard.sv
// load_use_hazard_unit: flags an ID instruction that reads the register a load in EX is writing
module load_use_hazard_unit #(
  parameter int W = 5
) (
  input  logic         ex_memread,
  input  logic [W-1:0] ex_rt,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  input  logic         id_valid,
  output logic         hz
);
  assign hz = id_valid & ex_memread & (|ex_rt) & ((ex_rt == rs) | (ex_rt == rt));
endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch flush and debug counters
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_in,
  input  logic                  RegDst_in,
  input  logic                  ALUSrc_in,
  input  logic                  MemToReg_in,
  input  logic                  RegWrite_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic                  Branch_in,
  input  logic [1:0]            ALUOp_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  branch_taken_in,
  output logic                  ex_ALUSrc_out,
  output logic [1:0]            ex_ALUOp_out,
  output logic [REG_ADDR_W-1:0] ex_dest_out,
  output logic                  mem_MemRead_out,
  output logic                  mem_MemWrite_out,
  output logic                  mem_branch_out,
  output logic                  mem_RegWrite_out,
  output logic [REG_ADDR_W-1:0] mem_dest_out,
  output logic                  wb_RegWrite_out,
  output logic                  wb_MemToReg_out,
  output logic [REG_ADDR_W-1:0] wb_dest_out,
  output logic                  pc_write_out,
  output logic                  ifid_write_out,
  output logic                  flush_ifid_out,
  output logic [CNT_W-1:0]      stall_count_out,
  output logic [CNT_W-1:0]      flush_count_out
);
  logic [CTRL_W-1:0] id_ctrl;
  logic ex_memread, ex_memwrite, ex_branch, ex_regwrite, ex_memtoreg, mem_memtoreg;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic hz, flush, stall, ld_ex;
  always_comb begin
    id_ctrl = '0;
    id_ctrl[C_REGDST] = RegDst_in;
    id_ctrl[C_ALUSRC] = ALUSrc_in;
    id_ctrl[C_MEMTOREG] = MemToReg_in;
    id_ctrl[C_REGWRITE] = RegWrite_in;
    id_ctrl[C_MEMREAD] = MemRead_in;
    id_ctrl[C_MEMWRITE] = MemWrite_in;
    id_ctrl[C_BRANCH] = Branch_in;
    id_ctrl[C_ALUOP+:2] = ALUOp_in;
  end
  load_use_hazard_unit #(.W(REG_ADDR_W)) u_hz (
    .ex_memread(ex_memread),
    .ex_rt(ex_rt),
    .rs(rs_in),
    .rt(rt_in),
    .id_valid(id_valid_in),
    .hz(hz)
  );
  assign flush = branch_taken_in & mem_branch_out;
  assign stall = hz & ~flush;
  assign ld_ex = id_valid_in & ~stall & ~flush;
  assign pc_write_out = ~stall;
  assign ifid_write_out = ~stall;
  assign flush_ifid_out = flush;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ALUSrc_out <= 1'b0;
      ex_ALUOp_out <= 2'b0;
      ex_dest_out <= '0;
      ex_rt <= '0;
      ex_memread <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      mem_MemRead_out <= 1'b0;
      mem_MemWrite_out <= 1'b0;
      mem_branch_out <= 1'b0;
      mem_RegWrite_out <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_dest_out <= '0;
      wb_RegWrite_out <= 1'b0;
      wb_MemToReg_out <= 1'b0;
      wb_dest_out <= '0;
      stall_count_out <= '0;
      flush_count_out <= '0;
    end else begin
      ex_ALUSrc_out <= ld_ex & id_ctrl[C_ALUSRC];
      ex_ALUOp_out <= ld_ex ? id_ctrl[C_ALUOP+:2] : 2'b0;
      ex_dest_out <= ld_ex ? (id_ctrl[C_REGDST] ? rd_in : rt_in) : '0;
      ex_rt <= ld_ex ? rt_in : '0;
      ex_memread <= ld_ex & id_ctrl[C_MEMREAD];
      ex_memwrite <= ld_ex & id_ctrl[C_MEMWRITE];
      ex_branch <= ld_ex & id_ctrl[C_BRANCH];
      ex_regwrite <= ld_ex & id_ctrl[C_REGWRITE];
      ex_memtoreg <= ld_ex & id_ctrl[C_MEMTOREG];
      mem_MemRead_out <= ~flush & ex_memread;
      mem_MemWrite_out <= ~flush & ex_memwrite;
      mem_branch_out <= ~flush & ex_branch;
      mem_RegWrite_out <= ~flush & ex_regwrite;
      mem_memtoreg <= ~flush & ex_memtoreg;
      mem_dest_out <= flush ? '0 : ex_dest_out;
      wb_RegWrite_out <= mem_RegWrite_out;
      wb_MemToReg_out <= mem_memtoreg;
      wb_dest_out <= mem_dest_out;
      if (stall && !(&stall_count_out)) stall_count_out <= stall_count_out + CNT_W'(1);
      if (flush && !(&flush_count_out)) flush_count_out <= flush_count_out + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed and random checks of control_pipeline against a stage-record model
module tb_control_pipeline;
  localparam int CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam int K_RT = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_NOP = 4;
  typedef struct packed {
    logic alusrc;
    logic [1:0] aluop;
    logic memread, memwrite, branch, regwrite, memtoreg;
    logic [4:0] dest, rt;
  } st_t;
  logic clk = 0;
  logic rst_n, v, rdst, asrc, mtr, rw, mr, mw, br, bt;
  logic [1:0] op;
  logic [4:0] rs, rt, rd;
  logic ex_alusrc, mem_mr, mem_mw, mem_br, mem_rw, wb_rw, wb_mtr, pc_write, ifid_write, flush_ifid;
  logic [1:0] ex_aluop;
  logic [4:0] ex_dest, mem_dest, wb_dest;
  logic [CNT_W-1:0] stall_count, flush_count;
  st_t m_ex, m_mem, m_wb;
  int m_sc, m_fc, n_chk, n_fail;
  always #5 clk = ~clk;
  control_pipeline #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_in(v),
    .RegDst_in(rdst), .ALUSrc_in(asrc), .MemToReg_in(mtr), .RegWrite_in(rw),
    .MemRead_in(mr), .MemWrite_in(mw), .Branch_in(br), .ALUOp_in(op),
    .rs_in(rs), .rt_in(rt), .rd_in(rd), .branch_taken_in(bt),
    .ex_ALUSrc_out(ex_alusrc), .ex_ALUOp_out(ex_aluop), .ex_dest_out(ex_dest),
    .mem_MemRead_out(mem_mr), .mem_MemWrite_out(mem_mw), .mem_branch_out(mem_br),
    .mem_RegWrite_out(mem_rw), .mem_dest_out(mem_dest),
    .wb_RegWrite_out(wb_rw), .wb_MemToReg_out(wb_mtr), .wb_dest_out(wb_dest),
    .pc_write_out(pc_write), .ifid_write_out(ifid_write), .flush_ifid_out(flush_ifid),
    .stall_count_out(stall_count), .flush_count_out(flush_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_op(input int k, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    rs = s;
    rt = t;
    rd = d;
    v = (k != K_NOP);
    {rdst, asrc, mtr, rw, mr, mw, br, op} = '0;
    if (k == K_RT) {rdst, rw, op} = {1'b1, 1'b1, 2'b10};
    if (k == K_LW) {asrc, mtr, rw, mr} = 4'b1111;
    if (k == K_SW) {asrc, mw} = 2'b11;
    if (k == K_BEQ) {br, op} = {1'b1, 2'b01};
  endtask
  task automatic step();
    logic hz, fl, st;
    #1;
    hz = v && m_ex.memread && m_ex.rt != 0 && (m_ex.rt == rs || m_ex.rt == rt);
    fl = bt && m_mem.branch;
    st = hz && !fl;
    chk("pc_write", 32'(pc_write), 32'(!st));
    chk("ifid_write", 32'(ifid_write), 32'(!st));
    chk("flush_ifid", 32'(flush_ifid), 32'(fl));
    chk("ex_alusrc", 32'(ex_alusrc), 32'(m_ex.alusrc));
    chk("ex_aluop", 32'(ex_aluop), 32'(m_ex.aluop));
    chk("ex_dest", 32'(ex_dest), 32'(m_ex.dest));
    chk("mem_memread", 32'(mem_mr), 32'(m_mem.memread));
    chk("mem_memwrite", 32'(mem_mw), 32'(m_mem.memwrite));
    chk("mem_branch", 32'(mem_br), 32'(m_mem.branch));
    chk("mem_regwrite", 32'(mem_rw), 32'(m_mem.regwrite));
    chk("mem_dest", 32'(mem_dest), 32'(m_mem.dest));
    chk("wb_regwrite", 32'(wb_rw), 32'(m_wb.regwrite));
    chk("wb_memtoreg", 32'(wb_mtr), 32'(m_wb.memtoreg));
    chk("wb_dest", 32'(wb_dest), 32'(m_wb.dest));
    chk("stall_count", 32'(stall_count), 32'(m_sc));
    chk("flush_count", 32'(flush_count), 32'(m_fc));
    @(posedge clk);
    if (!rst_n) begin
      m_ex = '0;
      m_mem = '0;
      m_wb = '0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      m_wb = m_mem;
      m_mem = fl ? '0 : m_ex;
      if (fl || st || !v) m_ex = '0;
      else m_ex = '{alusrc: asrc, aluop: op, memread: mr, memwrite: mw, branch: br,
                    regwrite: rw, memtoreg: mtr, dest: rdst ? rd : rt, rt: rt};
      if (st && m_sc < MAXC) m_sc++;
      if (fl && m_fc < MAXC) m_fc++;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 0;
    set_op(K_NOP, 0, 0, 0);
    step();
    rst_n = 1;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    m_ex = '0;
    m_mem = '0;
    m_wb = '0;
    m_sc = 0;
    m_fc = 0;
    bt = 0;
    rst_n = 0;
    set_op(K_NOP, 0, 0, 0);
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_pc_write", 32'(pc_write), 1);
    chk("rst_stall_count", 32'(stall_count), 0);
    chk("rst_ex_dest", 32'(ex_dest), 0);
    set_op(K_RT, 1, 3, 5);
    step();
    set_op(K_NOP, 0, 0, 0);
    chk("t1_ex_dest", 32'(ex_dest), 5);
    chk("t1_ex_aluop", 32'(ex_aluop), 2);
    step();
    chk("t1_mem_regwrite", 32'(mem_rw), 1);
    chk("t1_mem_dest", 32'(mem_dest), 5);
    step();
    chk("t1_wb_dest", 32'(wb_dest), 5);
    set_op(K_LW, 0, 8, 0);
    step();
    set_op(K_RT, 8, 9, 10);
    #1;
    chk("t2_pc_write", 32'(pc_write), 0);
    chk("t2_ifid_write", 32'(ifid_write), 0);
    step();
    chk("t2_stall_count", 32'(stall_count), 1);
    chk("t2_ex_bubble", 32'({ex_alusrc, ex_aluop, ex_dest}), 0);
    #1;
    chk("t2_pc_resume", 32'(pc_write), 1);
    step();
    chk("t2_add_in_ex", 32'(ex_dest), 10);
    do_reset();
    set_op(K_LW, 0, 0, 0);
    step();
    set_op(K_RT, 0, 4, 6);
    #1;
    chk("t3_pc_write", 32'(pc_write), 1);
    step();
    chk("t3_stall_count", 32'(stall_count), 0);
    set_op(K_BEQ, 1, 2, 0);
    step();
    set_op(K_LW, 0, 2, 0);
    step();
    set_op(K_RT, 2, 3, 7);
    bt = 1;
    #1;
    chk("t4_flush_ifid", 32'(flush_ifid), 1);
    chk("t4_pc_write", 32'(pc_write), 1);
    chk("t4_ifid_write", 32'(ifid_write), 1);
    step();
    bt = 0;
    chk("t4_flush_count", 32'(flush_count), 1);
    chk("t4_stall_count", 32'(stall_count), 0);
    chk("t4_ex_bubble", 32'({ex_alusrc, ex_aluop, ex_dest}), 0);
    chk("t4_mem_bubble", 32'({mem_mr, mem_rw, mem_br, mem_dest}), 0);
    do_reset();
    for (int i = 0; i < MAXC + 1; i++) begin
      set_op(K_LW, 0, 1, 0);
      step();
      set_op(K_RT, 1, 2, 3);
      step();
      step();
    end
    chk("t5_stall_sat", 32'(stall_count), MAXC);
    set_op(K_LW, 0, 4, 0);
    step();
    rst_n = 0;
    set_op(K_NOP, 0, 0, 0);
    step();
    rst_n = 1;
    chk("t6_ex_memread_gone", 32'({ex_alusrc, ex_aluop, ex_dest, mem_mr, mem_dest, wb_rw, wb_dest}), 0);
    chk("t6_counters", 32'({stall_count, flush_count}), 0);
    #1;
    chk("t6_pc_write", 32'(pc_write), 1);
    chk("t6_flush_ifid", 32'(flush_ifid), 0);
    for (int i = 0; i < 400; i++) begin
      set_op(int'($urandom_range(0, 4)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      if (!v) {rdst, asrc, mtr, rw, mr, mw, br, op} = 9'($urandom);
      bt = 1'($urandom);
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1;
    set_op(K_NOP, 0, 0, 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
